sipo_rx: RTL and testbench

//  Serial-In-Parallel-Out receiver: the far end of the PISO serial link.
//  - Samples one bit per clk while valid_in is high, MSB first, and assembles DATA_WIDTH-bit words.
//  - Presents each completed word on a valid/ready parallel interface toward the consumer.
//  - Flags link errors: frame gap, overrun and (optionally) parity.
//

---
 rtl/sipo_rx.sv | 181 ++++++++++++++++++
 tb/tb_sipo_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sipo_rx.sv
`default_nettype none
// ============================================================================
// Module   : sipo_rx
// Brief    : Serial-in parallel-out receiver. Assembles MSB-first words from
//            a valid-qualified bit stream and presents them on a valid/ready
//            port. Detects frame-gap timeout, overrun and (optionally) parity.
//            Optional even-parity bit per word: define SIPO_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_MAX    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  parity_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int GAP_W = $clog2(GAP_MAX + 1);

  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'(GAP_MAX - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef SIPO_RX_PARITY_EN
  localparam logic [1:0] S_PAR   = 2'd2;
`endif

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [CNT_W-1:0]      w_bit_cnt_nxt;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic [GAP_W-1:0]      w_gap_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [DATA_WIDTH-1:0] w_word;
  logic [DATA_WIDTH-1:0] w_commit_word;
  logic                  w_done;
  logic                  w_gap_abort;
  logic                  w_accept;
  logic                  w_par_fail;

  assign w_word = {r_shift[DATA_WIDTH-2:0], data_in};

`ifdef SIPO_RX_PARITY_EN
  // The data word has already been fully shifted in when the parity bit lands.
  assign w_commit_word = r_shift;
`else
  logic w_unused_msb;
  assign w_unused_msb  = r_shift[DATA_WIDTH-1];
  assign w_commit_word = w_word;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_shift_nxt   = r_shift;
    w_done        = 1'b0;
    w_gap_abort   = 1'b0;
    w_par_fail    = 1'b0;

    if (valid_in) begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt   = S_SHIFT;
          w_shift_nxt   = {{(DATA_WIDTH-1){1'b0}}, data_in};
          w_bit_cnt_nxt = CNT_W'(1);
          w_gap_cnt_nxt = '0;
        end
        S_SHIFT: begin
          w_gap_cnt_nxt = '0;
          if (r_bit_cnt == C_LAST_BIT) begin
`ifdef SIPO_RX_PARITY_EN
            w_state_nxt   = S_PAR;
            w_shift_nxt   = w_word;
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
`else
            w_done        = 1'b1;
            w_state_nxt   = S_IDLE;
            w_shift_nxt   = '0;
            w_bit_cnt_nxt = '0;
`endif
          end else begin
            w_shift_nxt   = w_word;
            w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          end
        end
`ifdef SIPO_RX_PARITY_EN
        S_PAR: begin
          // Even parity over data plus parity bit.
          if (^{r_shift, data_in} == 1'b0) begin
            w_done = 1'b1;
          end else begin
            w_par_fail = 1'b1;
          end
          w_state_nxt   = S_IDLE;
          w_shift_nxt   = '0;
          w_bit_cnt_nxt = '0;
          w_gap_cnt_nxt = '0;
        end
`endif
        default: begin
          w_state_nxt   = S_IDLE;
          w_shift_nxt   = '0;
          w_bit_cnt_nxt = '0;
          w_gap_cnt_nxt = '0;
        end
      endcase
    end else if (r_state != S_IDLE) begin
      // Inside a frame, idle cycles count toward the gap timeout.
      if (r_gap_cnt == C_GAP_LAST) begin
        w_gap_abort   = 1'b1;
        w_state_nxt   = S_IDLE;
        w_shift_nxt   = '0;
        w_bit_cnt_nxt = '0;
        w_gap_cnt_nxt = '0;
      end else begin
        w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
      end
    end
  end

  // A finished word may take the output register if it is empty or draining now.
  assign w_accept = w_done && (!valid_out || ready_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_shift   <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_shift   <= w_shift_nxt;
      frame_err <= w_gap_abort;
      overrun   <= w_done && valid_out && !ready_in;
      if (w_accept) begin
        data_out  <= w_commit_word;
        valid_out <= 1'b1;
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end
    end
  end

`ifdef SIPO_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= w_par_fail;
    end
  end
`else
  logic w_unused_par;
  assign w_unused_par = w_par_fail;
  assign parity_err   = 1'b0;
`endif

  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sipo_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_rx
// Brief    : Directed self-checking bench for sipo_rx (DATA_WIDTH=8, GAP_MAX=4).
//            Parity steps are active when SIPO_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_rx;

  localparam int W = 8;
  localparam int G = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         data_in;
  logic         valid_in;
  logic         ready_in;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         busy;
  logic         frame_err;
  logic         overrun;
  logic         parity_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sipo_rx #(.DATA_WIDTH(W), .GAP_MAX(G)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sends one word MSB first with valid_in held high (plus even parity bit when enabled).
  task automatic send_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) begin
      data_in  = w[i];
      valid_in = 1'b1;
      step();
      if (i == W / 2) check("busy_mid", {31'd0, busy}, 32'd1);
    end
`ifdef SIPO_RX_PARITY_EN
    data_in  = ^w;
    valid_in = 1'b1;
    step();
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    data_in  = 1'b0;
    valid_in = 1'b0;
    ready_in = 1'b1;
    step();
    step();
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_data",  {24'd0, data_out},  32'd0);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_ferr",  {31'd0, frame_err}, 32'd0);
    check("rst_ovr",   {31'd0, overrun},   32'd0);
    check("rst_perr",  {31'd0, parity_err},32'd0);
    rst = 1'b0;
    step();

    // Single word, consumer ready.
    send_word(8'h10);
    check("t1_valid", {31'd0, valid_out}, 32'd1);
    check("t1_data",  {24'd0, data_out},  32'h10);
    valid_in = 1'b0;
    step();
    check("t1_one_cycle", {31'd0, valid_out}, 32'd0);
    check("t1_hold",      {24'd0, data_out},  32'h10);

    // Back-to-back words, no idle cycles.
    send_word(8'h80);
    check("t2_v0", {31'd0, valid_out}, 32'd1);
    check("t2_d0", {24'd0, data_out},  32'h80);
    send_word(8'h07);
    check("t2_v1", {31'd0, valid_out}, 32'd1);
    check("t2_d1", {24'd0, data_out},  32'h07);
    send_word(8'h19);
    check("t2_v2", {31'd0, valid_out}, 32'd1);
    check("t2_d2", {24'd0, data_out},  32'h19);
    valid_in = 1'b0;
    step();
    check("t2_drained", {31'd0, valid_out}, 32'd0);

    // Consumer stalled: second word overruns.
    ready_in = 1'b0;
    send_word(8'hA5);
    check("t3_v_a5",  {31'd0, valid_out}, 32'd1);
    check("t3_d_a5",  {24'd0, data_out},  32'hA5);
    check("t3_no_ovr",{31'd0, overrun},   32'd0);
    send_word(8'h3C);
    check("t3_ovr",   {31'd0, overrun},   32'd1);
    check("t3_d_keep",{24'd0, data_out},  32'hA5);
    check("t3_v_keep",{31'd0, valid_out}, 32'd1);
    valid_in = 1'b0;
    step();
    check("t3_ovr_pulse", {31'd0, overrun}, 32'd0);
    ready_in = 1'b1;
    step();
    check("t3_drain_v", {31'd0, valid_out}, 32'd0);
    check("t3_drain_d", {24'd0, data_out},  32'hA5);
    step();
    check("t3_only_one", {31'd0, valid_out}, 32'd0);

    // Gap timeout after three bits.
    data_in  = 1'b1;
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) step();
    valid_in = 1'b0;
    for (int i = 0; i < G - 1; i++) step();
    check("t4_ferr_early", {31'd0, frame_err}, 32'd0);
    check("t4_busy_early", {31'd0, busy},      32'd1);
    step();
    check("t4_ferr",  {31'd0, frame_err}, 32'd1);
    check("t4_busy",  {31'd0, busy},      32'd0);
    check("t4_nov",   {31'd0, valid_out}, 32'd0);
    step();
    check("t4_ferr_pulse", {31'd0, frame_err}, 32'd0);
    send_word(8'h55);
    check("t4_v55", {31'd0, valid_out}, 32'd1);
    check("t4_d55", {24'd0, data_out},  32'h55);
    valid_in = 1'b0;
    step();

    // Asynchronous reset mid-frame with a held word.
    ready_in = 1'b0;
    send_word(8'h11);
    valid_in = 1'b0;
    step();
    check("t5_hold_v", {31'd0, valid_out}, 32'd1);
    check("t5_hold_d", {24'd0, data_out},  32'h11);
    for (int i = 0; i < 5; i++) begin
      data_in  = i[0];
      valid_in = 1'b1;
      step();
    end
    check("t5_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_v",    {31'd0, valid_out}, 32'd0);
    check("t5_rst_d",    {24'd0, data_out},  32'd0);
    check("t5_rst_busy", {31'd0, busy},      32'd0);
    check("t5_rst_ovr",  {31'd0, overrun},   32'd0);
    valid_in = 1'b0;
    rst      = 1'b0;
    ready_in = 1'b1;
    step();
    send_word(8'h22);
    check("t5_v22", {31'd0, valid_out}, 32'd1);
    check("t5_d22", {24'd0, data_out},  32'h22);
    valid_in = 1'b0;
    step();

`ifdef SIPO_RX_PARITY_EN
    // Good parity commits; bad parity drops the word.
    send_word(8'h03);
    check("t6_v03",   {31'd0, valid_out},  32'd1);
    check("t6_d03",   {24'd0, data_out},   32'h03);
    check("t6_perr0", {31'd0, parity_err}, 32'd0);
    valid_in = 1'b0;
    step();
    for (int i = W - 1; i >= 0; i--) begin
      data_in  = (i < 2) ? 1'b1 : 1'b0;
      valid_in = 1'b1;
      step();
    end
    data_in = 1'b1;
    step();
    check("t6_perr", {31'd0, parity_err}, 32'd1);
    check("t6_nov",  {31'd0, valid_out},  32'd0);
    valid_in = 1'b0;
    step();
    check("t6_perr_pulse", {31'd0, parity_err}, 32'd0);
`else
    check("t6_perr_tied", {31'd0, parity_err}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
